// File: rtl/stopwatch_controller_if.sv
// Button and display bundle for the stopwatch controller.
// master = board/bench side, slave = controller side.
interface stopwatch_controller_if;
  logic        BtnStartStop;
  logic        BtnLap;
  logic        BtnClear;
  logic [15:0] Result;
  logic        ScanSel;
  logic        Running;
  logic        Overflow;

  modport master (
    output BtnStartStop, BtnLap, BtnClear,
    input  Result, ScanSel, Running, Overflow
  );

  modport slave (
    input  BtnStartStop, BtnLap, BtnClear,
    output Result, ScanSel, Running, Overflow
  );
endinterface

// File: rtl/stopwatch_controller.sv
// 00.00-99.99 s BCD stopwatch with lap freeze and a free-running
// digit-scan divider for the multiplexed 7-segment display.
module stopwatch_controller #(
  parameter int TICK_DIV = 10000,
  parameter int SCAN_DIV = 500
) (
  input logic             CLK,
  input logic             RST,
  stopwatch_controller_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_LAP, S_PAUSE, S_DONE
  } state_e;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   lap_q, lap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q;
  logic          sel_q;
  logic [2:0]    s1_q, s2_q, s3_q;
  logic [2:0]    press;
  logic          clr_p, ss_p, lap_p;
  logic          counting, tick, full, ovf_tick;

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // {clear, start/stop, lap}: sync, then one-cycle rising-edge pulse
  assign press = s2_q & ~s3_q;
  assign clr_p = press[2];
  assign ss_p  = press[1];
  assign lap_p = press[0];

  assign counting = (state_q == S_RUN) ||
                    (state_q == S_LAP);
  assign tick     = counting && (presc_q == PMAX);
  assign full     = (count_q == 16'h9999);
  assign ovf_tick = tick && full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      lap_q   <= '0;
      presc_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      presc_q <= presc_d;
      s1_q    <= {io.BtnClear, io.BtnStartStop,
                  io.BtnLap};
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ss_p) state_d = S_RUN;
      end
      S_RUN: begin
        if (ovf_tick)   state_d = S_DONE;
        else if (ss_p)  state_d = S_PAUSE;
        else if (lap_p) state_d = S_LAP;
      end
      S_LAP: begin
        if (ovf_tick)   state_d = S_DONE;
        else if (ss_p)  state_d = S_PAUSE;
        else if (lap_p) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clr_p)     state_d = S_IDLE;
        else if (ss_p) state_d = S_RUN;
      end
      S_DONE: begin
        if (clr_p) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    lap_d   = lap_q;
    presc_d = presc_q;
    if (counting) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick && !full) begin
      count_d = bcd_inc(count_q);
    end
    // lap freezes the value the display showed before this edge
    if ((state_q == S_RUN) && !ovf_tick &&
        !ss_p && lap_p) begin
      lap_d = count_q;
    end
    if ((state_q == S_IDLE) ||
        (state_d == S_IDLE)) begin
      presc_d = '0;
    end
    if (state_d == S_IDLE) begin
      count_d = '0;
      lap_d   = '0;
    end
  end

  always_comb begin
    io.Result   = (state_q == S_LAP) ? lap_q : count_q;
    io.Running  = counting;
    io.Overflow = (state_q == S_DONE);
    io.ScanSel  = sel_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_q <= '0;
      sel_q  <= 1'b0;
    end else if (scan_q == SMAX) begin
      scan_q <= '0;
      sel_q  <= ~sel_q;
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge
// monitor pops and compares them against the live display bundle.
module tb_stopwatch_controller;

  typedef struct packed {
    logic [15:0] r;
    logic        run;
    logic        ovf;
    logic        scan;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   since = 0;
  exp_t  exp_q[$];
  string nm_q[$];

  stopwatch_controller_if sw_if ();

  stopwatch_controller #(
    .TICK_DIV(4),
    .SCAN_DIV(3)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .io (sw_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_cmp++;
      if ({sw_if.Result, sw_if.Running, sw_if.Overflow,
           sw_if.ScanSel} !== e) begin
        n_bad++;
        $display("FAIL %s: got R=%h run=%b ovf=%b scan=%b, want R=%h run=%b ovf=%b scan=%b",
                 nm, sw_if.Result, sw_if.Running,
                 sw_if.Overflow, sw_if.ScanSel,
                 e.r, e.run, e.ovf, e.scan);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) since = 0;
      else since++;
      #1;
    end
  endtask

  task automatic expect_out(input string nm,
                            input logic [15:0] r,
                            input logic run,
                            input logic ovf);
    exp_t e;
    e.r    = r;
    e.run  = run;
    e.ovf  = ovf;
    e.scan = ((since / 3) % 2) == 1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic press(input logic c, input logic s,
                       input logic l);
    sw_if.BtnClear     = c;
    sw_if.BtnStartStop = s;
    sw_if.BtnLap       = l;
    step(1);
    sw_if.BtnClear     = 1'b0;
    sw_if.BtnStartStop = 1'b0;
    sw_if.BtnLap       = 1'b0;
    step(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    sw_if.BtnClear     = 1'b0;
    sw_if.BtnStartStop = 1'b0;
    sw_if.BtnLap       = 1'b0;

    do_reset();
    expect_out("reset", 16'h0000, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(1);
      expect_out("scan", 16'h0000, 0, 0);
    end
    press(0, 0, 1);
    expect_out("idle_lap", 16'h0000, 0, 0);
    press(1, 0, 0);
    expect_out("idle_clr", 16'h0000, 0, 0);

    press(0, 1, 0);
    expect_out("run_start", 16'h0000, 1, 0);
    step(3);
    expect_out("pre_tick", 16'h0000, 1, 0);
    step(1);
    expect_out("first_tick", 16'h0001, 1, 0);
    step(32);
    expect_out("cnt9", 16'h0009, 1, 0);
    step(4);
    expect_out("cnt10", 16'h0010, 1, 0);
    step(120);
    expect_out("cnt40", 16'h0040, 1, 0);
    step(3836);
    expect_out("cnt999", 16'h0999, 1, 0);
    step(4);
    expect_out("cnt1000", 16'h1000, 1, 0);

    do_reset();
    expect_out("reset2", 16'h0000, 0, 0);
    press(0, 1, 0);
    step(492);
    expect_out("cnt123", 16'h0123, 1, 0);
    press(0, 0, 1);
    expect_out("lap_frz", 16'h0123, 1, 0);
    step(1);
    expect_out("lap_hold1", 16'h0123, 1, 0);
    step(20);
    expect_out("lap_hold2", 16'h0123, 1, 0);
    step(16);
    press(0, 0, 1);
    expect_out("lap_live", 16'h0133, 1, 0);
    press(0, 0, 1);
    expect_out("lap_again", 16'h0134, 1, 0);
    press(0, 1, 0);
    expect_out("lap_pause", 16'h0135, 0, 0);

    do_reset();
    press(0, 1, 0);
    step(20);
    expect_out("cnt5", 16'h0005, 1, 0);
    step(3);
    press(0, 1, 0);
    expect_out("pause", 16'h0006, 0, 0);
    step(50);
    expect_out("pause_hold", 16'h0006, 0, 0);
    press(0, 1, 0);
    expect_out("resume", 16'h0006, 1, 0);
    step(1);
    expect_out("resume1", 16'h0006, 1, 0);
    step(1);
    expect_out("resume2", 16'h0007, 1, 0);
    press(1, 0, 0);
    expect_out("run_clr", 16'h0007, 1, 0);
    press(0, 1, 0);
    expect_out("pause2", 16'h0008, 0, 0);
    press(1, 0, 0);
    expect_out("pause_clr", 16'h0000, 0, 0);
    press(0, 1, 0);
    expect_out("restart", 16'h0000, 1, 0);
    step(4);
    expect_out("restart_t", 16'h0001, 1, 0);

    do_reset();
    press(0, 1, 0);
    step(39992);
    expect_out("cnt9998", 16'h9998, 1, 0);
    step(4);
    expect_out("cnt9999", 16'h9999, 1, 0);
    step(4);
    expect_out("done", 16'h9999, 0, 1);
    step(100);
    expect_out("done_hold", 16'h9999, 0, 1);
    press(0, 1, 0);
    expect_out("done_ss", 16'h9999, 0, 1);
    press(0, 0, 1);
    expect_out("done_lap", 16'h9999, 0, 1);
    press(1, 0, 0);
    expect_out("done_clr", 16'h0000, 0, 0);

    press(0, 1, 0);
    step(4);
    expect_out("t6_cnt1", 16'h0001, 1, 0);
    press(0, 1, 0);
    expect_out("t6_pause", 16'h0001, 0, 0);
    press(1, 1, 1);
    expect_out("prio_clr", 16'h0000, 0, 0);
    press(0, 1, 0);
    expect_out("t6_run", 16'h0000, 1, 0);
    step(1);
    press(0, 1, 0);
    expect_out("ss_tick", 16'h0001, 0, 0);
    step(10);
    expect_out("ss_tick_h", 16'h0001, 0, 0);
    press(0, 1, 0);
    step(5);
    expect_out("mid_run", 16'h0002, 1, 0);

    sw_if.BtnLap = 1'b1;
    step(1);
    sw_if.BtnLap = 1'b0;
    step(1);
    rst = 1'b1;
    sw_if.BtnStartStop = 1'b1;
    step(1);
    expect_out("mid_rst", 16'h0000, 0, 0);
    rst = 1'b0;
    step(2);
    expect_out("held_wait", 16'h0000, 0, 0);
    step(1);
    expect_out("held_run", 16'h0000, 1, 0);
    step(8);
    expect_out("held_cnt", 16'h0002, 1, 0);
    sw_if.BtnStartStop = 1'b0;
    step(4);
    expect_out("held_once", 16'h0003, 1, 0);

    step(2);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequencing controller for the two-module 7-segment display path: produces the 4-digit packed BCD `Result` word and the digit-scan select that drives the display multiplexer.
- Implements a 00.00–99.99 s stopwatch with start/stop, lap-freeze and clear buttons.
- Includes a count prescaler and a free-running scan divider.
- Sits between the board buttons and the segment display driver.

Parameters:
TICK_DIV, 10000, CLK cycles per count increment (0.01 s at 1 MHz); must be >= 2
SCAN_DIV, 500, CLK cycles between ScanSel toggles; must be >= 1

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
BtnStartStop  input  1  start/stop button level, asynchronous, debounced externally
BtnLap  input  1  lap button level, asynchronous
BtnClear  input  1  clear button level, asynchronous
Result  output  16  packed BCD [15:12]=tens s, [11:8]=units s, [7:4]=tenths, [3:0]=hundredths
ScanSel  output  1  display scan select; 1 = upper digit of each pair, 0 = lower digit
Running  output  1  high in RUN and LAP
Overflow  output  1  high in DONE

Behaviour:
- Reset (RST sampled high at an edge) loads the following values. All outputs therefore reset to 0.
  - state=IDLE
  - count=0000
  - lap=0000
  - prescaler=0
  - scan counter=0
  - ScanSel=0
  - all sync/edge flops=0
- Button path: 2-flop synchronizer, then rising-edge detect against a third flop. The press pulse is 1 cycle. The state reacts at the 3rd rising edge at which the input is sampled high. A button held through reset release yields exactly one press.
- Priority when several pulses coincide: Clear > StartStop > Lap.
- States and transitions:
  - IDLE: count=0. StartStop → RUN with prescaler forced to 0. Lap and Clear are ignored.
  - RUN: StartStop → PAUSE. Lap → LAP; lap ← count value before that edge. Clear is ignored.
  - LAP: counting continues and Result shows lap. Lap → RUN (display live). StartStop → PAUSE (display live). Clear is ignored.
  - PAUSE: StartStop → RUN with the prescaler value retained. Clear → IDLE with count=0, lap=0, prescaler=0. Lap is ignored.
  - DONE: count holds 9999 and Overflow=1. Clear → IDLE. All other buttons are ignored.
- Prescaler:
  - Increments in RUN and LAP only; holds in PAUSE and DONE.
  - When the prescaler equals TICK_DIV-1 that cycle is a tick: the prescaler wraps to 0 and count is updated at the same edge.
  - First increment is visible TICK_DIV edges after entering RUN from IDLE.
- Count is BCD with per-digit wrap 9→0 and carry into the next digit. Digits never hold 0xA–0xF.
- Tick while count==9999 → DONE; count stays 9999 and there is no wrap.
- Tick coinciding with StartStop in RUN/LAP: the increment is committed and the state goes to PAUSE.
- Tick coinciding with Lap: lap captures the pre-increment count and count increments.
- Result is the lap register in LAP, and the count register in all other states. Output is registered, 0-cycle mux from those registers.
- ScanSel:
  - Scan counter counts 0..SCAN_DIV-1 in every state; ScanSel toggles at wrap.
  - Period is 2*SCAN_DIV cycles. It is unaffected by buttons and cleared only by RST.
- RST mid-run overrides everything at that edge, including coincident button pulses.

Test Plan:
- Reset, then release: Result=0000, ScanSel=0, Running=0, Overflow=0; with SCAN_DIV=3, ScanSel toggles every 3 cycles (0,0,0,1,1,1,…).
- TICK_DIV=4, pulse StartStop: Running=1 at 3rd edge; Result=0001 four edges later; after 40 ticks Result=0040; at count 0009 the next tick gives 0010; at 0999 the next gives 1000.
- Lap at count 0123: Result frozen at 0123 while the internal count advances; Lap again after 10 ticks gives Result=0133. StartStop in LAP gives PAUSE with live value shown.
- Pause at prescaler=2 and wait 50 cycles: Result is unchanged. Restart: next increment after 2 cycles (not 4). Clear in PAUSE gives Result=0000 and IDLE; Clear while RUN is ignored.
- Preload count 9998 via run: 9999 after 1 tick, then next tick gives DONE, Overflow=1, Result=9999 held for 100 cycles. StartStop is ignored; Clear gives 0000, Overflow=0.
- Clear, StartStop and Lap pulsed the same cycle in PAUSE gives IDLE (Clear wins). StartStop and tick in the same cycle in RUN gives increment plus PAUSE. RST asserted mid-RUN: all outputs 0 next edge.
